// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: instruction/PC
// constants and the IF/ID pipeline register payload.
package fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Word-aligned fetch: the two low address bits are always cleared.
    localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [INSTR_W-1:0] instruction;
        logic [31:0]        pc_plus4;
        logic               valid;
    } ifid_t;

    // Bubble contents loaded on reset or flush.
    function automatic ifid_t ifid_bubble(input logic [INSTR_W-1:0] nop);
        ifid_t b;
        b.instruction = nop;
        b.pc_plus4    = '0;
        b.valid       = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register. Reset and flush both load a bubble; otherwise
// the register loads when i_load is high and holds when it is low.
// There is no valid/ready handshake here: the hazard unit's stall is a
// plain hold (i_load low) and a redirect is a plain flush, both applied
// unconditionally on the next rising edge.
module if_id_register
    import fetch_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP = NOP_INSTR
) (
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_load,
    input  logic  i_flush,
    input  ifid_t i_d,
    output ifid_t o_q
);

    ifid_t r_q;

    // Bubble on reset/flush, capture on load, otherwise hold.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_q <= ifid_bubble(NOP);
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives it to the instruction memory and
// captures the returned instruction plus PC+4 into the IF/ID register.
// Priority of controls: Rst > Redirect > Stall > normal fetch.
// Optional performance counters are enabled with macro IF_PERF_COUNT_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = fetch_pkg::DEFAULT_RESET_PC,
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Stall,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectPC,
    output logic [ADDR_W-1:0] IMemAddress,
    input  logic [31:0]       IMemInstruction,
    output logic [ADDR_W-1:0] PC,
    output logic [31:0]       IFID_Instruction,
    output logic [31:0]       IFID_PCPlus4,
    output logic              IFID_Valid
`ifdef IF_PERF_COUNT_EN
    ,
    output logic [31:0]       FetchCount,
    output logic [31:0]       StallCount
`endif
);

    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_plus4;
    logic [ADDR_W-1:0]  w_redirect_pc;
    fetch_pkg::ifid_t   w_ifid_d;
    fetch_pkg::ifid_t   w_ifid_q;

    // PC+4 wraps modulo 2^32 with no overflow indication.
    assign w_pc_plus4    = r_pc + fetch_pkg::PC_INC;
    assign w_redirect_pc = RedirectPC & fetch_pkg::ALIGN_MASK;

    // Program counter: boot address, redirect target, hold, or advance.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pc <= RESET_PC;
        end else if (Redirect) begin
            r_pc <= w_redirect_pc;
        end else if (!Stall) begin
            r_pc <= w_pc_plus4;
        end
    end

    // Payload captured on a normal fetch edge.
    always_comb begin
        w_ifid_d.instruction = IMemInstruction;
        w_ifid_d.pc_plus4    = w_pc_plus4;
        w_ifid_d.valid       = 1'b1;
    end

    if_id_register #(
        .NOP     (NOP_INSTR)
    ) u_if_id (
        .i_clk   (Clk),
        .i_rst   (Rst),
        .i_load  (!Stall),
        .i_flush (Redirect),
        .i_d     (w_ifid_d),
        .o_q     (w_ifid_q)
    );

    assign IMemAddress      = r_pc;
    assign PC               = r_pc;
    assign IFID_Instruction = w_ifid_q.instruction;
    assign IFID_PCPlus4     = w_ifid_q.pc_plus4;
    assign IFID_Valid       = w_ifid_q.valid;

`ifdef IF_PERF_COUNT_EN
    logic        w_fetch_evt;
    logic        w_stall_evt;
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    assign w_fetch_evt = !Rst && !Redirect && !Stall;
    assign w_stall_evt = !Rst && !Redirect &&  Stall;

    // Saturating event counters for fetched instructions and stalled edges.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_fetch_evt && (r_fetch_count != 32'hFFFF_FFFF)) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_stall_evt && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign FetchCount = r_fetch_count;
    assign StallCount = r_stall_count;
`else
    // Counters not built: no extra state or ports.
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. Two instances share the
// control inputs: "a" boots from 0, "b" boots from 0xFFFF_FFFC to cover
// PC wrap. Each has its own combinational memory model, mem[i] = i*4.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic [31:0] a_imem_addr, a_imem_instr, a_pc, a_instr, a_p4;
    logic        a_valid;
    logic [31:0] b_imem_addr, b_imem_instr, b_pc, b_instr, b_p4;
    logic        b_valid;
`ifdef IF_PERF_COUNT_EN
    logic [31:0] a_fetch_cnt, a_stall_cnt, b_fetch_cnt, b_stall_cnt;
`endif

    logic [31:0]  mem [64];
    logic [128:0] got;
    logic [128:0] exp;
    int           n_tests;
    int           n_fail;

    assign a_imem_instr = mem[a_imem_addr[7:2]];
    assign b_imem_instr = mem[b_imem_addr[7:2]];

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .Clk              (clk),
        .Rst              (rst),
        .Stall            (stall),
        .Redirect         (redirect),
        .RedirectPC       (redirect_pc),
        .IMemAddress      (a_imem_addr),
        .IMemInstruction  (a_imem_instr),
        .PC               (a_pc),
        .IFID_Instruction (a_instr),
        .IFID_PCPlus4     (a_p4),
        .IFID_Valid       (a_valid)
`ifdef IF_PERF_COUNT_EN
        ,
        .FetchCount       (a_fetch_cnt),
        .StallCount       (a_stall_cnt)
`endif
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .Clk              (clk),
        .Rst              (rst),
        .Stall            (stall),
        .Redirect         (redirect),
        .RedirectPC       (redirect_pc),
        .IMemAddress      (b_imem_addr),
        .IMemInstruction  (b_imem_instr),
        .PC               (b_pc),
        .IFID_Instruction (b_instr),
        .IFID_PCPlus4     (b_p4),
        .IFID_Valid       (b_valid)
`ifdef IF_PERF_COUNT_EN
        ,
        .FetchCount       (b_fetch_cnt),
        .StallCount       (b_stall_cnt)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle so outputs are sampled away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        step(); step();
        got = {a_imem_addr, a_pc, a_instr, a_p4, a_valid};
        exp = {32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_a: got %h expected %h", got, exp); end
        got = {b_imem_addr, b_pc, b_instr, b_p4, b_valid};
        exp = {32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0};
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_b: got %h expected %h", got, exp); end
    endtask

    task automatic test_free_run();
        logic [31:0] pc_e;
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            pc_e = 32'(i * 4);
            got = {a_imem_addr, a_pc, a_instr, a_p4, a_valid};
            exp = {pc_e, pc_e, pc_e - 32'd4, pc_e, 1'b1};
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL free_run_edge%0d: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            got = {a_imem_addr, a_pc, a_instr, a_p4, a_valid};
            exp = {32'h10, 32'h10, 32'h0C, 32'h10, 1'b1};
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL stall_hold%0d: got %h expected %h", i, got, exp); end
        end
        stall = 1'b0;
        step();
        got = {a_imem_addr, a_pc, a_instr, a_p4, a_valid};
        exp = {32'h14, 32'h14, 32'h10, 32'h14, 1'b1};
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL stall_release: got %h expected %h", got, exp); end
        step();
        got = {a_imem_addr, a_pc, a_instr, a_p4, a_valid};
        exp = {32'h18, 32'h18, 32'h14, 32'h18, 1'b1};
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL stall_no_dup: got %h expected %h", got, exp); end
    endtask

    task automatic test_redirect();
        rst = 1'b1; step();
        rst = 1'b0; step(); step();
        got = {a_imem_addr, a_pc, a_instr, a_p4, a_valid};
        exp = {32'h08, 32'h08, 32'h04, 32'h08, 1'b1};
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL redirect_setup: got %h expected %h", got, exp); end
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        got = {a_imem_addr, a_pc, a_instr, a_p4, a_valid};
        exp = {32'h40, 32'h40, 32'h0, 32'h0, 1'b0};
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL redirect_flush: got %h expected %h", got, exp); end
        redirect = 1'b0;
        step();
        got = {a_imem_addr, a_pc, a_instr, a_p4, a_valid};
        exp = {32'h44, 32'h44, 32'h40, 32'h44, 1'b1};
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL redirect_target: got %h expected %h", got, exp); end
    endtask

    task automatic test_redirect_stall();
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h23;
        step();
        got = {a_imem_addr, a_pc, a_instr, a_p4, a_valid};
        exp = {32'h20, 32'h20, 32'h0, 32'h0, 1'b0};
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL redirect_over_stall: got %h expected %h", got, exp); end
        redirect = 1'b0;
        step();
        got = {a_imem_addr, a_pc, a_instr, a_p4, a_valid};
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL stall_after_flush: got %h expected %h", got, exp); end
        stall = 1'b0;
        step();
        got = {a_imem_addr, a_pc, a_instr, a_p4, a_valid};
        exp = {32'h24, 32'h24, 32'h20, 32'h24, 1'b1};
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL fetch_after_aligned_redirect: got %h expected %h", got, exp); end
    endtask

    task automatic test_reset_priority();
        rst = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
        step();
        got = {a_imem_addr, a_pc, a_instr, a_p4, a_valid};
        exp = {32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_priority: got %h expected %h", got, exp); end
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;
        step();
        got = {a_imem_addr, a_pc, a_instr, a_p4, a_valid};
        exp = {32'h04, 32'h04, 32'h0, 32'h04, 1'b1};
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL first_fetch_after_reset: got %h expected %h", got, exp); end
    endtask

    task automatic test_wrap();
        rst = 1'b1; step();
        rst = 1'b0;
        step();
        got = {b_imem_addr, b_pc, b_instr, b_p4, b_valid};
        exp = {32'h0, 32'h0, 32'hFC, 32'h0, 1'b1};
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL wrap_first_fetch: got %h expected %h", got, exp); end
        step();
        got = {b_imem_addr, b_pc, b_instr, b_p4, b_valid};
        exp = {32'h04, 32'h04, 32'h0, 32'h04, 1'b1};
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL wrap_second_fetch: got %h expected %h", got, exp); end
        step();
        got = {b_imem_addr, b_pc, b_instr, b_p4, b_valid};
        exp = {32'h08, 32'h08, 32'h04, 32'h08, 1'b1};
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL wrap_third_fetch: got %h expected %h", got, exp); end
        rst = 1'b1;
        step();
        got = {b_imem_addr, b_pc, b_instr, b_p4, b_valid};
        exp = {32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0};
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL wrap_mid_reset: got %h expected %h", got, exp); end
        rst = 1'b0;
    endtask

`ifdef IF_PERF_COUNT_EN
    task automatic test_perf_count();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0;
        step();
        n_tests++;
        if ({a_fetch_cnt, a_stall_cnt} !== 64'h0) begin
            n_fail++; $display("FAIL perf_reset: got %h/%h expected 0/0", a_fetch_cnt, a_stall_cnt);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) step();
        stall = 1'b0;
        n_tests++;
        if ((a_fetch_cnt !== 32'd10) || (a_stall_cnt !== 32'd4)) begin
            n_fail++; $display("FAIL perf_counts: got %0d/%0d expected 10/4", a_fetch_cnt, a_stall_cnt);
        end
    endtask
`endif

    // Main sequence and final report
    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i * 4);
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_reset_priority();
        test_wrap();
`ifdef IF_PERF_COUNT_EN
        test_perf_count();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
